// File: rtl/vreg_value_file_if.sv
// Bundle of dispatch, commit, writeback and lookup signals around the vreg value file.
// The master side is the pipeline driving requests; the slave side is the value file.
interface vreg_value_file_if #(
  parameter int VREG_W = 5,
  parameter int XLEN   = 32
);
  logic              flush;
  logic              alloc_req;
  logic              alloc_grant;
  logic [VREG_W-1:0] alloc_vregid;
  logic              free_en;
  logic [VREG_W-1:0] free_vregid;
  logic              wb_en;
  logic [VREG_W-1:0] wb_vregid;
  logic [XLEN-1:0]   wb_val;
  logic [VREG_W-1:0] rd1_vregid;
  logic              rd1_ready;
  logic [XLEN-1:0]   rd1_val;
  logic [VREG_W-1:0] rd2_vregid;
  logic              rd2_ready;
  logic [XLEN-1:0]   rd2_val;
  logic [VREG_W:0]   free_count;
  logic              free_ovf_err;

  modport master (
    output flush, alloc_req, free_en, free_vregid, wb_en, wb_vregid, wb_val,
           rd1_vregid, rd2_vregid,
    input  alloc_grant, alloc_vregid, rd1_ready, rd1_val, rd2_ready, rd2_val,
           free_count, free_ovf_err
  );

  modport slave (
    input  flush, alloc_req, free_en, free_vregid, wb_en, wb_vregid, wb_val,
           rd1_vregid, rd2_vregid,
    output alloc_grant, alloc_vregid, rd1_ready, rd1_val, rd2_ready, rd2_val,
           free_count, free_ovf_err
  );
endinterface

// File: rtl/vreg_value_file.sv
// Virtual-register value file with circular free list, ready bits and
// same-cycle writeback bypass on both operand lookups.
module vreg_value_file #(
  parameter int NUM_VREG = 32,
  parameter int VREG_W   = 5,
  parameter int XLEN     = 32
) (
  input logic              clk,
  input logic              rst_n,
  vreg_value_file_if.slave bus
);
  localparam logic [VREG_W:0] FULL_CNT = (VREG_W+1)'(NUM_VREG);
  localparam logic [VREG_W:0] ONE_CNT  = (VREG_W+1)'(1);

  logic [VREG_W-1:0]   fl_r [NUM_VREG];
  logic [XLEN-1:0]     val_r [NUM_VREG];
  logic [VREG_W-1:0]   head_r;
  logic [VREG_W-1:0]   tail_r;
  logic [VREG_W:0]     count_r;
  logic [VREG_W:0]     count_nxt_s;
  logic [NUM_VREG-1:0] ready_r;
  logic [NUM_VREG-1:0] ready_nxt_s;
  logic                ovf_r;
  logic                grant_s;
  logic                free_acc_s;
  logic                free_rej_s;
  logic [VREG_W-1:0]   head_id_s;

  assign head_id_s = fl_r[head_r];

  // Accept/reject decisions; flush suppresses every list operation.
  always_comb begin
    grant_s    = bus.alloc_req & (count_r != '0) & ~bus.flush;
    free_acc_s = bus.free_en & (count_r != FULL_CNT) & ~bus.flush;
    free_rej_s = bus.free_en & (count_r == FULL_CNT) & ~bus.flush;
  end

  // Next free count from accepted free and granted alloc.
  always_comb begin
    count_nxt_s = count_r;
    case ({free_acc_s, grant_s})
      2'b10:   count_nxt_s = count_r + ONE_CNT;
      2'b01:   count_nxt_s = count_r - ONE_CNT;
      default: count_nxt_s = count_r;
    endcase
  end

  // Ready bits: later statements win, giving free > alloc > writeback.
  always_comb begin
    ready_nxt_s = ready_r;
    if (bus.flush) begin
      ready_nxt_s = '0;
    end else begin
      ready_nxt_s[bus.wb_vregid]  = ready_nxt_s[bus.wb_vregid] | bus.wb_en;
      ready_nxt_s[head_id_s]      = ready_nxt_s[head_id_s] & ~grant_s;
      ready_nxt_s[bus.free_vregid] = ready_nxt_s[bus.free_vregid] & ~free_acc_s;
    end
  end

  // Free list, pointers, count, ready bits and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VREG; i++) fl_r[i] <= VREG_W'(i);
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= FULL_CNT;
      ready_r <= '0;
      ovf_r   <= 1'b0;
    end else if (bus.flush) begin
      for (int i = 0; i < NUM_VREG; i++) fl_r[i] <= VREG_W'(i);
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= FULL_CNT;
      ready_r <= '0;
    end else begin
      if (grant_s) head_r <= head_r + VREG_W'(1);
      if (free_acc_s) begin
        fl_r[tail_r] <= bus.free_vregid;
        tail_r       <= tail_r + VREG_W'(1);
      end
      count_r <= count_nxt_s;
      ready_r <= ready_nxt_s;
      ovf_r   <= ovf_r | free_rej_s;
    end
  end

  // Value storage written by the writeback broadcast.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VREG; i++) val_r[i] <= '0;
    end else if (bus.wb_en & ~bus.flush) begin
      val_r[bus.wb_vregid] <= bus.wb_val;
    end
  end

  // Operand lookups bypass a writeback to the same vreg in the same cycle.
  always_comb begin
    if (bus.wb_en && (bus.wb_vregid == bus.rd1_vregid)) begin
      bus.rd1_ready = 1'b1;
      bus.rd1_val   = bus.wb_val;
    end else begin
      bus.rd1_ready = ready_r[bus.rd1_vregid];
      bus.rd1_val   = val_r[bus.rd1_vregid];
    end
    if (bus.wb_en && (bus.wb_vregid == bus.rd2_vregid)) begin
      bus.rd2_ready = 1'b1;
      bus.rd2_val   = bus.wb_val;
    end else begin
      bus.rd2_ready = ready_r[bus.rd2_vregid];
      bus.rd2_val   = val_r[bus.rd2_vregid];
    end
  end

  assign bus.alloc_grant  = grant_s;
  assign bus.alloc_vregid = head_id_s;
  assign bus.free_count   = count_r;
  assign bus.free_ovf_err = ovf_r;
endmodule

// File: tb/tb_vreg_value_file.sv
// Bench for vreg_value_file: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_vreg_value_file;
  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  vreg_value_file_if #(.VREG_W(5), .XLEN(32)) bus();

  vreg_value_file #(.NUM_VREG(32), .VREG_W(5), .XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: free list as a FIFO queue of ids, plus per-vreg ready/value.
  logic [4:0]  m_fl [$];
  bit          m_ready [32];
  logic [31:0] m_val [32];
  bit          m_ovf;
  logic [4:0]  m_head;
  bit          m_g;
  bit          m_f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic m_reset_list();
    m_fl.delete();
    for (int i = 0; i < 32; i++) begin
      m_fl.push_back(5'(i));
      m_ready[i] = 1'b0;
    end
  endtask

  task automatic m_reset();
    m_reset_list();
    for (int i = 0; i < 32; i++) m_val[i] = 32'h0;
    m_ovf = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare process: check outputs against the model mid-cycle, then advance the model.
  initial begin
    m_reset();
    #3;
    forever begin
      @(negedge clk);
      if (!rst_n) m_reset();
      m_g = bus.alloc_req && (m_fl.size() != 0) && !bus.flush;
      chk("alloc_grant", 32'(bus.alloc_grant), 32'(m_g));
      if (m_fl.size() != 0) chk("alloc_vregid", 32'(bus.alloc_vregid), 32'(m_fl[0]));
      chk("free_count", 32'(bus.free_count), 32'(m_fl.size()));
      chk("free_ovf_err", 32'(bus.free_ovf_err), 32'(m_ovf));
      if (bus.wb_en && bus.wb_vregid == bus.rd1_vregid) begin
        chk("rd1_ready_byp", 32'(bus.rd1_ready), 32'd1);
        chk("rd1_val_byp", bus.rd1_val, bus.wb_val);
      end else begin
        chk("rd1_ready", 32'(bus.rd1_ready), 32'(m_ready[bus.rd1_vregid]));
        if (m_ready[bus.rd1_vregid]) chk("rd1_val", bus.rd1_val, m_val[bus.rd1_vregid]);
      end
      if (bus.wb_en && bus.wb_vregid == bus.rd2_vregid) begin
        chk("rd2_ready_byp", 32'(bus.rd2_ready), 32'd1);
        chk("rd2_val_byp", bus.rd2_val, bus.wb_val);
      end else begin
        chk("rd2_ready", 32'(bus.rd2_ready), 32'(m_ready[bus.rd2_vregid]));
        if (m_ready[bus.rd2_vregid]) chk("rd2_val", bus.rd2_val, m_val[bus.rd2_vregid]);
      end
      if (rst_n) begin
        if (bus.flush) begin
          m_reset_list();
        end else begin
          m_f = bus.free_en && (m_fl.size() != 32);
          if (bus.free_en && m_fl.size() == 32) m_ovf = 1'b1;
          if (bus.wb_en) begin
            m_val[bus.wb_vregid]   = bus.wb_val;
            m_ready[bus.wb_vregid] = 1'b1;
          end
          if (m_g) begin
            m_head = m_fl.pop_front();
            m_ready[m_head] = 1'b0;
          end
          if (m_f) begin
            m_fl.push_back(bus.free_vregid);
            m_ready[bus.free_vregid] = 1'b0;
          end
        end
      end
    end
  end

  // Directed scenarios with hand-computed expectations, then random traffic.
  initial begin
    rst_n = 1'b1;
    bus.flush = 1'b0; bus.alloc_req = 1'b0; bus.free_en = 1'b0; bus.free_vregid = 5'd0;
    bus.wb_en = 1'b0; bus.wb_vregid = 5'd0; bus.wb_val = 32'h0;
    bus.rd1_vregid = 5'd0; bus.rd2_vregid = 5'd1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_free_count", 32'(bus.free_count), 32'd32);
    chk("rst_alloc_vregid", 32'(bus.alloc_vregid), 32'd0);
    chk("rst_rd1_ready", 32'(bus.rd1_ready), 32'd0);
    chk("rst_rd1_val", bus.rd1_val, 32'h0);
    chk("rst_ovf", 32'(bus.free_ovf_err), 32'd0);
    step();
    rst_n = 1'b1;

    // Three back-to-back grants hand out 0, 1, 2.
    bus.alloc_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t1_grant", 32'(bus.alloc_grant), 32'd1);
      chk("t1_vregid", 32'(bus.alloc_vregid), 32'(k));
      step();
    end
    bus.alloc_req = 1'b0;
    #1 chk("t1_count", 32'(bus.free_count), 32'd29);

    // Drain the list; a free at empty is not re-granted in the same cycle.
    bus.alloc_req = 1'b1;
    repeat (29) step();
    #1 chk("t2_grant_empty", 32'(bus.alloc_grant), 32'd0);
    chk("t2_count_empty", 32'(bus.free_count), 32'd0);
    bus.free_en = 1'b1; bus.free_vregid = 5'd7;
    #1 chk("t2_grant_same_cycle", 32'(bus.alloc_grant), 32'd0);
    step();
    bus.free_en = 1'b0;
    #1 chk("t2_vregid_7", 32'(bus.alloc_vregid), 32'd7);
    chk("t2_grant_7", 32'(bus.alloc_grant), 32'd1);
    step();
    bus.alloc_req = 1'b0;

    // Writeback bypass, then registered visibility.
    bus.wb_en = 1'b1; bus.wb_vregid = 5'd5; bus.wb_val = 32'hDEADBEEF; bus.rd1_vregid = 5'd5;
    #1 chk("t3_byp_ready", 32'(bus.rd1_ready), 32'd1);
    chk("t3_byp_val", bus.rd1_val, 32'hDEADBEEF);
    step();
    bus.wb_en = 1'b0; bus.rd2_vregid = 5'd5;
    #1 chk("t3_reg_ready", 32'(bus.rd1_ready), 32'd1);
    chk("t3_reg_val", bus.rd1_val, 32'hDEADBEEF);
    chk("t3_rd2_val", bus.rd2_val, 32'hDEADBEEF);

    // Simultaneous alloc and free at count 10.
    for (int i = 0; i < 10; i++) begin
      bus.free_en = 1'b1; bus.free_vregid = 5'(10 + i);
      step();
    end
    bus.free_en = 1'b0;
    #1 chk("t4_count10", 32'(bus.free_count), 32'd10);
    bus.alloc_req = 1'b1; bus.free_en = 1'b1; bus.free_vregid = 5'd20;
    #1 chk("t4_vregid_10", 32'(bus.alloc_vregid), 32'd10);
    step();
    bus.alloc_req = 1'b0; bus.free_en = 1'b0;
    #1 chk("t4_count_kept", 32'(bus.free_count), 32'd10);
    chk("t4_head_adv", 32'(bus.alloc_vregid), 32'd11);
    bus.alloc_req = 1'b1;
    repeat (9) step();
    #1 chk("t4_tail_adv", 32'(bus.alloc_vregid), 32'd20);
    step();
    bus.alloc_req = 1'b0;

    // Overflow at full is sticky across flush.
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    #1 chk("t5_flush_count", 32'(bus.free_count), 32'd32);
    bus.free_en = 1'b1; bus.free_vregid = 5'd3;
    step();
    bus.free_en = 1'b0;
    #1 chk("t5_ovf", 32'(bus.free_ovf_err), 32'd1);
    chk("t5_count", 32'(bus.free_count), 32'd32);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    #1 chk("t5_ovf_kept", 32'(bus.free_ovf_err), 32'd1);

    // Flush after allocs and writeback, then async reset mid-burst.
    bus.alloc_req = 1'b1;
    repeat (20) step();
    bus.alloc_req = 1'b0;
    bus.wb_en = 1'b1; bus.wb_vregid = 5'd3; bus.wb_val = 32'h00001234;
    step();
    bus.wb_en = 1'b0; bus.rd1_vregid = 5'd3;
    #1 chk("t6_ready3", 32'(bus.rd1_ready), 32'd1);
    chk("t6_count12", 32'(bus.free_count), 32'd12);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    #1 chk("t6_flush_count", 32'(bus.free_count), 32'd32);
    chk("t6_flush_ready3", 32'(bus.rd1_ready), 32'd0);
    chk("t6_flush_vregid", 32'(bus.alloc_vregid), 32'd0);
    bus.alloc_req = 1'b1;
    repeat (5) step();
    #1 rst_n = 1'b0;
    #1 chk("t6_rst_count", 32'(bus.free_count), 32'd32);
    chk("t6_rst_vregid", 32'(bus.alloc_vregid), 32'd0);
    chk("t6_rst_ovf", 32'(bus.free_ovf_err), 32'd0);
    chk("t6_rst_ready3", 32'(bus.rd1_ready), 32'd0);
    step();
    rst_n = 1'b1; bus.alloc_req = 1'b0;
    step();

    // Random traffic in alternating alloc-heavy and free-heavy phases.
    for (int c = 0; c < 2000; c++) begin
      bit free_heavy;
      free_heavy = ((c / 100) % 2) == 1;
      bus.alloc_req   = ($urandom_range(99) < (free_heavy ? 20 : 80));
      bus.free_en     = ($urandom_range(99) < (free_heavy ? 75 : 25));
      bus.free_vregid = 5'($urandom_range(31));
      bus.wb_en       = 1'($urandom_range(1));
      bus.wb_vregid   = 5'($urandom_range(31));
      bus.wb_val      = 32'($urandom());
      bus.flush       = ($urandom_range(79) == 0);
      bus.rd1_vregid  = ($urandom_range(1) == 0) ? bus.wb_vregid : 5'($urandom_range(31));
      bus.rd2_vregid  = ($urandom_range(2) == 0) ? bus.wb_vregid : 5'($urandom_range(31));
      step();
    end
    bus.alloc_req = 1'b0; bus.free_en = 1'b0; bus.wb_en = 1'b0; bus.flush = 1'b0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
